mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port Memory (cmd_start/cmd_ready/rdata_valid handshake) between the
//  instruction-fetch port and the data load/store port. Arbitration is fixed priority
//  with anti-starvation. One command is in flight at a time.
//  Sits between the core's fetch/LSU logic and the Memory instance.
// PARAMETERS
//  DATA_FIRST    1  1: the data port wins a simultaneous request; 0: the fetch port wins
//  STARVE_LIMIT  4  consecutive grants to one port before a waiting other port is forced in (>=1)
// PORTS
//  clk              in   1   clock; all logic on posedge
//  reset            in   1   synchronous, active-high reset
//  i_req            in   1   fetch request; i_addr held stable while i_req=1
//  i_ready          out  1   fetch request accepted this cycle when i_req && i_ready
//  i_addr           in   32  fetch address
//  i_rdata          out  32  fetched instruction; held until the next fetch completes
//  i_rvalid         out  1   1-cycle pulse: i_rdata holds the fetched instruction
//  d_req            in   1   data request
//  d_write          in   1   1=store, 0=load; sampled on acceptance
//  d_ready          out  1   data request accepted this cycle when d_req && d_ready
//  d_addr           in   32  data address
//  d_wdata          in   32  store data
//  d_wmask          in   32  store bit mask
//  d_rdata          out  32  load data; held until the next load completes
//  d_rvalid         out  1   1-cycle pulse: d_rdata holds the load result (loads only)
//  mem_cmd_start    out  1   command strobe to Memory
//  mem_cmd_write    out  1   command is a write
//  mem_cmd_ready    in   1   Memory can take a command this cycle
//  mem_addr         out  32  command address
//  mem_wdata        out  32  write data
//  mem_wmask        out  32  write mask
//  mem_rdata        in   32  Memory read data
//  mem_rdata_valid  in   1   mem_rdata valid this cycle
// BEHAVIOUR
//  - Reset: state=IDLE. mem_cmd_start, mem_cmd_write, i_rvalid and d_rvalid are 0.
//    mem_addr, mem_wdata, mem_wmask, i_rdata and d_rdata are 0.
//    Streak counter=0; last_winner=none. i_ready and d_ready are 0 while reset=1.
//  - States: IDLE -> ISSUE -> (WAIT_READ | IDLE) -> IDLE.
//  - IDLE: grant is combinational from the requests; only the granted port sees ready=1.
//    * Only one port requests: it is granted.
//    * Both request and streak>=STARVE_LIMIT: the port that is not last_winner is granted.
//    * Both request otherwise: the DATA_FIRST priority decides.
//    * On acceptance, latch port id, write flag, addr, wdata and wmask; go to ISSUE.
//      last_winner=port. streak = (port==last_winner) ? sat_inc(streak) : 1.
//      streak is 3 bits and saturates at 7.
//  - ISSUE: mem_cmd_start=1 with the latched mem_cmd_write/addr/wdata/wmask.
//    The command is taken in the cycle where mem_cmd_ready=1.
//    Then a write goes to IDLE and a read goes to WAIT_READ.
//    Holds indefinitely while mem_cmd_ready=0. mem_cmd_start=0 in every other state.
//  - WAIT_READ: on mem_rdata_valid, register mem_rdata into i_rdata or d_rdata
//    (per the latched port). Pulse that port's rvalid in the next cycle. Go to IDLE.
//  - Latency with Memory always ready:
//    * Load: accept at T, issue at T+1, rvalid one cycle after mem_rdata_valid.
//    * Store: accept at T, issue at T+1, ready again at T+2.
//  - mem_rdata_valid seen in IDLE or ISSUE is ignored (stale read after reset).
//  - A request deasserted before acceptance is dropped without side effects.
//  - A request that is accepted always completes; the requester must not withdraw it.
//  - Reset mid-operation: state returns to IDLE in the next cycle.
//    Any pending rvalid is suppressed; the latched command is discarded.
//  - The rvalid pulse for the previous read can occur in the same cycle as a new
//    acceptance in IDLE; both must be handled in that cycle.
// TESTING
//  - Fetch only: i_req=1, i_addr=0x100, mem_rdata=0x00000013 with ready always 1
//    -> one mem read at 0x100; i_rvalid=1 for 1 cycle; i_rdata=0x00000013.
//  - Store: d_req=1, d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wmask=0xFFFFFFFF
//    -> mem_cmd_write=1 for exactly one cycle; d_rvalid never asserts; d_ready=1 two cycles later.
//  - Contention, DATA_FIRST=1: i_req and d_req both held for loads
//    -> order D,D,D,D,I,D,D,D,D,I (STARVE_LIMIT=4).
//  - Back-pressure: mem_cmd_ready=0 for 5 cycles during ISSUE
//    -> mem_cmd_start is held with a stable addr; exactly one command is issued.
//  - Reset in WAIT_READ, then mem_rdata_valid=1 one cycle after reset
//    -> no rvalid; i_rdata and d_rdata stay 0.
//  - Load then load: d_rdata holds 0xA between completions; it changes to 0xB only
//    with the second d_rvalid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port Memory between the instruction-fetch port and the
// data load/store port. Fixed priority between the ports, with a streak
// counter that forces the waiting port in after STARVE_LIMIT consecutive
// grants to the other one. Exactly one command is in flight at any time.
module mem_port_arbiter #(
  parameter bit DATA_FIRST   = 1'b1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  input  logic        d_req,
  input  logic        d_write,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_READ = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Latched command (valid from acceptance until the command completes)
  logic        r_port;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_wmask;

  // Arbitration history: r_last_valid=0 means no winner since reset
  logic [2:0]  r_streak;
  logic        r_last_valid;
  logic        r_last_port;

  logic        w_starve;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_accept;
  logic        w_port;
  logic [2:0]  w_streak_inc;

  // Grant decision and ready outputs; only meaningful while idle and out of reset
  always_comb begin
    w_starve  = i_req && d_req && r_last_valid && (int'(r_streak) >= STARVE_LIMIT);
    w_grant_d = 1'b0;
    if (d_req && !i_req) begin
      w_grant_d = 1'b1;
    end else if (d_req && i_req) begin
      w_grant_d = w_starve ? (r_last_port == PORT_I) : DATA_FIRST;
    end
    w_grant_i    = i_req && !w_grant_d;
    i_ready      = (r_state == ST_IDLE) && !reset && w_grant_i;
    d_ready      = (r_state == ST_IDLE) && !reset && w_grant_d;
    w_accept     = i_ready || d_ready;
    w_port       = d_ready ? PORT_D : PORT_I;
    w_streak_inc = (r_streak == 3'd7) ? 3'd7 : r_streak + 3'd1;
  end

  // Next-state logic for the single-command sequencer
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_cmd_ready) w_state_next = r_write ? ST_IDLE : ST_WAIT_READ;
      end
      ST_WAIT_READ: begin
        if (mem_rdata_valid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Latch the accepted command and update the winner streak
  always_ff @(posedge clk) begin
    if (reset) begin
      r_port       <= PORT_I;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_streak     <= '0;
      r_last_valid <= 1'b0;
      r_last_port  <= PORT_I;
    end else if (w_accept) begin
      r_port       <= w_port;
      r_write      <= (w_port == PORT_D) && d_write;
      r_addr       <= (w_port == PORT_D) ? d_addr : i_addr;
      r_wdata      <= (w_port == PORT_D) ? d_wdata : '0;
      r_wmask      <= (w_port == PORT_D) ? d_wmask : '0;
      r_streak     <= (r_last_valid && (r_last_port == w_port)) ? w_streak_inc : 3'd1;
      r_last_valid <= 1'b1;
      r_last_port  <= w_port;
    end
  end

  // Per-port read return: capture data and pulse rvalid one cycle later.
  // Data returning outside WAIT_READ (stale after reset) is ignored.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic        w_capture;
      logic        r_valid;
      logic [31:0] r_data;

      assign w_capture = (r_state == ST_WAIT_READ) && mem_rdata_valid &&
                         (r_port == ((gi == 1) ? PORT_D : PORT_I));

      // Hold the last result until the next completion for this port
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else begin
          r_valid <= w_capture;
          if (w_capture) r_data <= mem_rdata;
        end
      end
    end
  endgenerate

  assign i_rdata       = g_port[0].r_data;
  assign i_rvalid      = g_port[0].r_valid;
  assign d_rdata       = g_port[1].r_data;
  assign d_rvalid      = g_port[1].r_valid;

  assign mem_cmd_start = (r_state == ST_ISSUE);
  assign mem_cmd_write = (r_state == ST_ISSUE) && r_write;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized run,
// all checked against a transaction-level reference model (grant history,
// expected read queue, reference memory image) plus a simple Memory responder.
module tb_mem_port_arbiter;

  localparam bit DATA_FIRST   = 1'b1;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, i_ready, i_rvalid;
  logic [31:0] i_addr = '0, i_rdata;
  logic        d_req = 1'b0, d_write = 1'b0, d_ready, d_rvalid;
  logic [31:0] d_addr = '0, d_wdata = '0, d_wmask = '0, d_rdata;
  logic        mem_cmd_start, mem_cmd_write;
  logic        mem_cmd_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdata_valid = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_FIRST(DATA_FIRST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_write(d_write), .d_ready(d_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write), .mem_cmd_ready(mem_cmd_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  // ---------------- Memory responder ----------------
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  int          rd_lat  = 0;
  bit          rd_pend = 1'b0;
  int          rd_wait = 0;
  logic [31:0] rd_data = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    mem_rdata_valid <= 1'b0;
    if (rd_pend) begin
      if (rd_wait == 0) begin
        mem_rdata_valid <= 1'b1;
        mem_rdata       <= rd_data;
        rd_pend = 1'b0;
      end else begin
        rd_wait = rd_wait - 1;
      end
    end
    if (mem_cmd_start === 1'b1 && mem_cmd_ready) begin
      if (mem_cmd_write)
        phys_mem[mem_addr] = (phys_read(mem_addr) & ~mem_wmask) | (mem_wdata & mem_wmask);
      else begin
        rd_pend = 1'b1;
        rd_wait = rd_lat;
        rd_data = phys_read(mem_addr);
      end
    end
  end

  // ---------------- Reference model state ----------------
  typedef struct packed { logic port; logic [31:0] data; } rd_t;

  int          checks = 0, failures = 0;
  int          cyc = 0;
  bit          outstanding = 1'b0, issued = 1'b0, clear_next = 1'b0;
  int          age = 0;
  logic        cur_write = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, cur_wmask = '0;
  rd_t         exp_q[$];
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
  bit          hist[$];
  bit          i_acc = 1'b0, d_acc = 1'b0;
  int          cmd_taken_cnt = 0, write_cycles = 0;
  int          rv_cnt [2] = '{0, 0};
  int          last_rv_cyc [2] = '{0, 0};
  int          last_valid_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Winner under contention, from the grant history: a run of STARVE_LIMIT or
  // more grants to one port hands the next grant to the other port.
  function automatic bit exp_winner_d();
    int run = 0;
    if (hist.size() == 0) return DATA_FIRST;
    for (int k = hist.size() - 1; k >= 0 && hist[k] == hist[hist.size() - 1]; k--) run++;
    if (run > 7) run = 7;
    if (run >= STARVE_LIMIT) return !hist[hist.size() - 1];
    return DATA_FIRST;
  endfunction

  // Called once per cycle at the sampling point (4 time units after posedge)
  task automatic monitor();
    logic        rv [2];
    logic [31:0] rd [2];
    bit          exp_d, exp_i;
    cyc++;
    if (clear_next) begin outstanding = 1'b0; clear_next = 1'b0; end
    if (mem_rdata_valid === 1'b1) last_valid_cyc = cyc;
    rv[0] = i_rvalid; rv[1] = d_rvalid;
    rd[0] = i_rdata;  rd[1] = d_rdata;
    for (int p = 0; p < 2; p++) begin
      if (rv[p] === 1'b1) begin
        rv_cnt[p]++;
        last_rv_cyc[p] = cyc;
        if (exp_q.size() == 0 || exp_q[0].port != p[0]) begin
          chk($sformatf("rvalid_spurious_p%0d", p), rv[p], 1'b0);
        end else begin
          exp_rdata[p] = exp_q[0].data;
          void'(exp_q.pop_front());
          outstanding = 1'b0;
          age = 0;
        end
      end
      chk($sformatf("rdata_p%0d", p), rd[p], exp_rdata[p]);
    end
    if (mem_cmd_write === 1'b1) write_cycles++;
    if (mem_cmd_start === 1'b1) begin
      if (!outstanding || issued) begin
        chk("cmd_spurious", mem_cmd_start, 1'b0);
      end else begin
        chk("cmd_addr", mem_addr, cur_addr);
        chk("cmd_write", mem_cmd_write, cur_write);
        if (cur_write) begin
          chk("cmd_wdata", mem_wdata, cur_wdata);
          chk("cmd_wmask", mem_wmask, cur_wmask);
        end
        if (mem_cmd_ready) begin
          issued = 1'b1;
          cmd_taken_cnt++;
          if (cur_write) clear_next = 1'b1;
        end
      end
    end
    if (reset || outstanding) begin
      chk("i_ready_busy", i_ready, 1'b0);
      chk("d_ready_busy", d_ready, 1'b0);
    end else begin
      exp_d = d_req && (!i_req || exp_winner_d());
      exp_i = i_req && !exp_d;
      chk("i_ready_grant", i_ready, exp_i);
      chk("d_ready_grant", d_ready, exp_d);
    end
    i_acc = !reset && i_req && (i_ready === 1'b1);
    d_acc = !reset && d_req && (d_ready === 1'b1);
    if (i_acc || d_acc) begin
      outstanding = 1'b1; issued = 1'b0; age = 0;
      hist.push_back(d_acc);
      cur_write = d_acc && d_write;
      cur_addr  = d_acc ? d_addr : i_addr;
      cur_wdata = d_wdata;
      cur_wmask = d_wmask;
      if (cur_write)
        ref_mem[cur_addr] = (ref_read(cur_addr) & ~cur_wmask) | (cur_wdata & cur_wmask);
      else
        exp_q.push_back('{port: d_acc, data: ref_read(cur_addr)});
    end
    if (outstanding) begin
      age++;
      if (age > 60) begin
        chk("txn_timeout", outstanding, 1'b0);
        outstanding = 1'b0;
        exp_q.delete();
      end
    end
    if (reset) begin
      outstanding = 1'b0; issued = 1'b0; clear_next = 1'b0;
      exp_q.delete(); hist.delete();
      exp_rdata[0] = '0; exp_rdata[1] = '0;
    end
  endtask

  task automatic end_cycle();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #3;
    end_cycle();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && outstanding; k++) step();
    chk("drain", outstanding, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] order;
    bit         exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int         n, wc0, d0, taken0;
    bit         got;

    ref_mem[32'h100]  = 32'h00000013; phys_mem[32'h100]  = 32'h00000013;
    ref_mem[32'h400]  = 32'h0000000A; phys_mem[32'h400]  = 32'h0000000A;
    ref_mem[32'h404]  = 32'h0000000B; phys_mem[32'h404]  = 32'h0000000B;

    // Reset state
    repeat (3) @(posedge clk);
    #4;
    chk("rst_cmd_start", mem_cmd_start, 1'b0);
    chk("rst_cmd_write", mem_cmd_write, 1'b0);
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", mem_wmask, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    i_req = 1'b1; d_req = 1'b1;
    #1;
    chk("rst_i_ready", i_ready, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // Fetch only
    i_req = 1'b1; i_addr = 32'h100;
    #3; chk("fetch_ready", i_ready, 1'b1); chk("fetch_d_ready", d_ready, 1'b0); end_cycle();
    i_req = 1'b0;
    #3; chk("fetch_start", mem_cmd_start, 1'b1); chk("fetch_addr", mem_addr, 32'h100);
    chk("fetch_is_read", mem_cmd_write, 1'b0); end_cycle();
    repeat (10) step();
    chk("fetch_rvalid_count", rv_cnt[0], 1);
    chk("fetch_rdata", i_rdata, 32'h00000013);
    chk("fetch_rvalid_latency", last_rv_cyc[0], last_valid_cyc + 1);

    // Store: accepted at T, issued at T+1, ready again at T+2
    wc0 = write_cycles; d0 = rv_cnt[1];
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_wmask = 32'hFFFFFFFF;
    #3; chk("store_accept", d_ready, 1'b1); end_cycle();
    #3; chk("store_busy", d_ready, 1'b0); chk("store_cmd_write", mem_cmd_write, 1'b1); end_cycle();
    #3; chk("store_ready_again", d_ready, 1'b1); chk("store_write_once", write_cycles - wc0, 1); end_cycle();
    d_req = 1'b0; d_write = 1'b0;
    repeat (6) step();
    chk("store_no_d_rvalid", rv_cnt[1] - d0, 0);

    // Contention from a fresh reset: D,D,D,D,I,D,D,D,D,I
    reset = 1'b1; step(); reset = 1'b0;
    order = 'x; n = 0;
    i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h300;
    for (int k = 0; k < 300 && n < 10; k++) begin
      step();
      if (i_acc || d_acc) begin order[n] = d_acc; n++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 10; k++) chk($sformatf("contention_%0d", k), order[k], exp_order[k]);
    wait_idle();

    // Back-pressure: command held with a stable address, issued once
    mem_cmd_ready = 1'b0; i_req = 1'b1; i_addr = 32'h180;
    #3; chk("bp_accept", i_ready, 1'b1); end_cycle();
    i_req = 1'b0; taken0 = cmd_taken_cnt;
    for (int k = 0; k < 5; k++) begin
      #3; chk("bp_start_held", mem_cmd_start, 1'b1); chk("bp_addr_stable", mem_addr, 32'h180); end_cycle();
    end
    mem_cmd_ready = 1'b1;
    #3; chk("bp_start_final", mem_cmd_start, 1'b1); end_cycle();
    repeat (6) step();
    chk("bp_one_command", cmd_taken_cnt - taken0, 1);
    wait_idle();

    // Load then load: d_rdata holds 0xA until the second pulse brings 0xB
    d0 = rv_cnt[1];
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h400; step(); d_req = 1'b0;
    for (int k = 0; k < 20 && rv_cnt[1] == d0; k++) step();
    chk("ll_first", d_rdata, 32'h0000000A);
    repeat (3) step();
    rd_lat = 3; got = 1'b0;
    d_req = 1'b1; d_addr = 32'h404; step(); d_req = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #3;
      if (d_rvalid === 1'b1) begin chk("ll_second", d_rdata, 32'h0000000B); got = 1'b1; end
      else chk("ll_hold", d_rdata, 32'h0000000A);
      end_cycle();
    end
    chk("ll_second_seen", got, 1'b1);
    rd_lat = 0;
    wait_idle();

    // Reset in WAIT_READ; the read data arrives the cycle after reset
    d0 = rv_cnt[1];
    d_req = 1'b1; d_addr = 32'h408; step(); d_req = 1'b0;
    step();
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("rst_wait_i_rvalid", i_rvalid, 1'b0); chk("rst_wait_d_rvalid", d_rvalid, 1'b0);
      chk("rst_wait_i_rdata", i_rdata, 32'h0);  chk("rst_wait_d_rdata", d_rdata, 32'h0);
      end_cycle();
    end

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      mem_cmd_ready = ($urandom_range(0, 3) != 0);
      rd_lat = $urandom_range(0, 3);
      if (i_req && i_acc) i_req = 1'b0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = 32'h500 + 32'($urandom_range(0, 7)) * 4;
      end else if (i_req && $urandom_range(0, 19) == 0) i_req = 1'b0;
      if (d_req && d_acc) d_req = 1'b0;
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_write = $urandom_range(0, 1) == 1;
        d_addr  = 32'h500 + 32'($urandom_range(0, 7)) * 4;
        d_wdata = $urandom;
        case ($urandom_range(0, 3))
          0: d_wmask = 32'hFFFFFFFF;
          1: d_wmask = 32'hFFFF0000;
          2: d_wmask = 32'h000000FF;
          default: d_wmask = $urandom;
        endcase
      end else if (d_req && $urandom_range(0, 19) == 0) d_req = 1'b0;
      step();
    end
    i_req = 1'b0; d_req = 1'b0; mem_cmd_ready = 1'b1; rd_lat = 0;
    wait_idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
